// File: rtl/prbs_pkg.sv
// Shared constants for the PRBS17 checker: state encoding and default LFSR geometry.
package prbs_pkg;

    localparam int DEF_LFSR_W = 17;
    localparam int DEF_TAP_HI = 17;
    localparam int DEF_TAP_LO = 14;

    typedef enum logic [1:0] {
        SEED    = 2'd0,
        CHECK   = 2'd1,
        LOCKED  = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

endpackage

// File: rtl/prbs_predictor.sv
// Local LFSR for the PRBS17 checker: loads received bits while seeding, self-advances afterwards.
module prbs_predictor
    import prbs_pkg::*;
#(
    parameter int LFSR_W = DEF_LFSR_W,
    parameter int TAP_HI = DEF_TAP_HI,
    parameter int TAP_LO = DEF_TAP_LO
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic load,
    input  logic din,
    output logic p,
    output logic load_zero
);

    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] load_nx;

    assign load_nx   = {lfsr[LFSR_W-2:0], din};
    assign p         = lfsr[TAP_HI-1] ^ lfsr[TAP_LO-1];
    // Flags a seed that would leave the register stuck at zero.
    assign load_zero = ~|load_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lfsr <= '0;
        else if (en)
            lfsr <= load ? load_nx : {lfsr[LFSR_W-2:0], p};
    end

endmodule

// File: rtl/prbs17_checker.sv
// Self-synchronizing PRBS17 checker with lock FSM, windowed loss-of-lock and saturating error count.
// Optional CHK_BITCNT_EN adds bit_count (valid bits seen while locked) for BER measurement.
module prbs17_checker
    import prbs_pkg::*;
#(
    parameter int LFSR_W     = DEF_LFSR_W,
    parameter int TAP_HI     = DEF_TAP_HI,
    parameter int TAP_LO     = DEF_TAP_LO,
    parameter int LOCK_CNT   = 32,
    parameter int WIN_LEN    = 64,
    parameter int UNLOCK_ERR = 8,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
`ifdef CHK_BITCNT_EN
    output logic [31:0]      bit_count,
`endif
    output logic [1:0]       state_out
);

    localparam int FILL_W  = $clog2(LFSR_W + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WIN_LEN + 1);
    localparam int WERR_W  = $clog2(UNLOCK_ERR + 1);

    state_t             state, state_nx;
    logic [FILL_W-1:0]  fill;
    logic [MATCH_W-1:0] match;
    logic [WIN_W-1:0]   win;
    logic [WERR_W-1:0]  werr;
    logic               p, load_zero, e;
    logic               fill_done, match_done, win_wrap, err_hit, unlock;

    prbs_predictor #(
        .LFSR_W (LFSR_W),
        .TAP_HI (TAP_HI),
        .TAP_LO (TAP_LO)
    ) u_pred (
        .clk       (clk),
        .reset     (reset),
        .en        (bit_valid),
        .load      (state == SEED),
        .din       (bit_in),
        .p         (p),
        .load_zero (load_zero)
    );

    assign e          = bit_in ^ p;
    assign fill_done  = fill == FILL_W'(LFSR_W - 1);
    assign match_done = match == MATCH_W'(LOCK_CNT - 1);
    assign win_wrap   = win == WIN_W'(WIN_LEN - 1);
    assign err_hit    = (state == LOCKED) && bit_valid && e;
    // Unlock takes precedence over a window wrap on the same bit.
    assign unlock     = err_hit && (werr == WERR_W'(UNLOCK_ERR - 1));
    assign state_out  = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= SEED;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            SEED:    if (bit_valid && fill_done && !load_zero) state_nx = CHECK;
            CHECK: begin
                if (bit_valid) begin
                    if (e)               state_nx = SEED;
                    else if (match_done) state_nx = LOCKED;
                end
            end
            LOCKED:  if (unlock) state_nx = SEED;
            default: state_nx = SEED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill  <= '0;
            match <= '0;
            win   <= '0;
            werr  <= '0;
        end else if (bit_valid) begin
            fill  <= (state == SEED && !fill_done) ? fill + FILL_W'(1) : '0;
            match <= (state == CHECK && !e && !match_done) ? match + MATCH_W'(1) : '0;
            if (state == LOCKED && !unlock) begin
                win  <= win_wrap ? '0 : win + WIN_W'(1);
                werr <= win_wrap ? '0 : werr + WERR_W'(e);
            end else begin
                win  <= '0;
                werr <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            locked    <= state_nx == LOCKED;
            err_pulse <= err_hit;
            if (clear_err)
                err_count <= '0;
            else if (err_hit && err_count != '1)
                err_count <= err_count + ERR_W'(1);
        end
    end

`ifdef CHK_BITCNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bit_count <= '0;
        else if (clear_err)
            bit_count <= '0;
        else if (bit_valid && state == LOCKED && bit_count != '1)
            bit_count <= bit_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_prbs17_checker.sv
// Directed + randomized bench for prbs17_checker against a queue-based reference model.
module tb_prbs17_checker;

    logic        clk = 1'b0;
    logic        reset, bit_in, bit_valid, clear_err;
    logic        locked_a, pulse_a, locked_b, pulse_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    logic [1:0]  st_a, st_b;
`ifdef CHK_BITCNT_EN
    logic [31:0] bc_a, bc_b;
`endif

    always #5 clk = ~clk;

    prbs17_checker dut_a (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .clear_err (clear_err),
        .locked    (locked_a),
        .err_pulse (pulse_a),
        .err_count (cnt_a),
`ifdef CHK_BITCNT_EN
        .bit_count (bc_a),
`endif
        .state_out (st_a)
    );

    prbs17_checker #(.ERR_W(4)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .clear_err (clear_err),
        .locked    (locked_b),
        .err_pulse (pulse_b),
        .err_count (cnt_b),
`ifdef CHK_BITCNT_EN
        .bit_count (bc_b),
`endif
        .state_out (st_b)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: the local sequence is kept as the last 17 bits in a queue.
    bit     hq[$];
    int     m_st, m_fill, m_match, m_win, m_werr, m_raw;
    bit     m_pulse;
    longint m_bc;

    // Pattern source: x[n] = x[n-17] ^ x[n-14], first 17 bits are the seed MSB-first.
    bit          gq[$];
    int          gn;
    logic [16:0] gseed = 17'h1;

    function automatic bit gen_next();
        bit b;
        if (gn < 17) b = gseed[16-gn];
        else         b = gq[0] ^ gq[3];
        gq.push_back(b);
        if (gq.size() > 17) void'(gq.pop_front());
        gn++;
        return b;
    endfunction

    function automatic void m_reset();
        m_st = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0; m_raw = 0;
        m_pulse = 0; m_bc = 0;
        hq.delete();
        repeat (17) hq.push_back(1'b0);
    endfunction

    function automatic void m_push(bit x);
        hq.push_back(x);
        void'(hq.pop_front());
    endfunction

    function automatic void m_step(bit b, bit v, bit c);
        bit p, e, zero, was_locked;
        m_pulse = 0;
        if (v) begin
            was_locked = (m_st == 2);
            p = hq[0] ^ hq[3];
            e = b ^ p;
            case (m_st)
                0: begin
                    m_push(b);
                    m_fill++;
                    if (m_fill == 17) begin
                        m_fill = 0;
                        zero = 1;
                        foreach (hq[i]) if (hq[i]) zero = 0;
                        if (!zero) m_st = 1;
                    end
                end
                1: begin
                    m_push(p);
                    if (e) begin m_st = 0; m_match = 0; end
                    else begin
                        m_match++;
                        if (m_match == 32) begin m_match = 0; m_st = 2; end
                    end
                end
                default: begin
                    m_push(p);
                    m_win++;
                    if (e) begin m_pulse = 1; m_raw++; m_werr++; end
                    if (m_werr == 8) begin m_st = 0; m_win = 0; m_werr = 0; end
                    else if (m_win == 64) begin m_win = 0; m_werr = 0; end
                end
            endcase
            if (was_locked && m_bc < 64'hFFFF_FFFF) m_bc++;
        end
        if (c) begin m_raw = 0; m_bc = 0; end
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("state",       st_a,     m_st);
        chk("locked",      locked_a, m_st == 2);
        chk("err_pulse",   pulse_a,  m_pulse);
        chk("err_count",   cnt_a,    sat(m_raw, 65535));
        chk("state_b",     st_b,     m_st);
        chk("err_pulse_b", pulse_b,  m_pulse);
        chk("err_count_b", cnt_b,    sat(m_raw, 15));
`ifdef CHK_BITCNT_EN
        chk("bit_count",   bc_a,     m_bc);
        chk("bit_count_b", bc_b,     m_bc);
`endif
    endtask

    // Inputs change at the falling edge; outputs are checked at the next falling edge.
    task automatic cyc(input bit b, input bit v, input bit c);
        bit_in = b; bit_valid = v; clear_err = c;
        @(posedge clk);
        m_step(b, v, c);
        @(negedge clk);
        compare_all();
    endtask

    task automatic vbit(input bit flip, input bit c);
        bit b;
        b = gen_next() ^ flip;
        cyc(b, 1'b1, c);
    endtask

    task automatic do_reset();
        bit_in = 0; bit_valid = 0; clear_err = 0;
        reset = 1;
        m_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset = 0;
    endtask

    task automatic lock_count(input string tag);
        int n;
        n = 0;
        while (!locked_a && n < 300) begin vbit(0, 0); n++; end
        chk(tag, n, 49);
    endtask

    task automatic align_window();
        int g;
        g = 0;
        while (m_win != 0 && g < 100) begin vbit(0, 0); g++; end
    endtask

    initial begin
        int n, cyc_n;
        gn = 0;
        do_reset();
        chk("rst_locked", locked_a, 0);
        chk("rst_count",  cnt_a,    0);
        chk("rst_state",  st_a,     0);

        // Clean stream: lock at valid bit 49, no errors over 10000 bits
        lock_count("lock_at_49");
        repeat (9951) vbit(0, 0);
        chk("clean_count", cnt_a, 0);

        // Single flipped bit
        vbit(1, 0);
        chk("single_pulse", pulse_a, 1);
        vbit(0, 0);
        chk("single_pulse_off", pulse_a, 0);
        repeat (100) vbit(0, 0);
        chk("single_count",  cnt_a,    1);
        chk("single_locked", locked_a, 1);

        // Eight errors in one window force unlock, then relock
        vbit(0, 1);
        align_window();
        for (int i = 0; i < 8; i++) begin
            vbit(1, 0);
            if (i < 7) repeat (2) vbit(0, 0);
        end
        chk("unlock_locked", locked_a, 0);
        chk("unlock_state",  st_a,     0);
        chk("unlock_count",  cnt_a,    8);
        lock_count("relock_49");
        chk("relock_count", cnt_a, 8);

        // Eighth error on the wrap bit still unlocks
        align_window();
        repeat (56) vbit(0, 0);
        repeat (8) vbit(1, 0);
        chk("wrap_unlock", locked_a, 0);
        lock_count("relock_wrap");

        // Errors straddling a wrap do not accumulate
        align_window();
        repeat (60) vbit(0, 0);
        repeat (8) vbit(1, 0);
        chk("straddle_locked", locked_a, 1);

        // All-zero stream never leaves SEED
        do_reset();
        repeat (1000) cyc(0, 1, 0);
        chk("zero_state",  st_a,     0);
        chk("zero_locked", locked_a, 0);

        // Sparse bit_valid, then asynchronous reset while locked
        do_reset();
        n = 0; cyc_n = 0;
        while (!locked_a && n < 300) begin
            cyc($urandom_range(0, 1), 0, 0);
            cyc($urandom_range(0, 1), 0, 0);
            vbit(0, 0);
            n++; cyc_n += 3;
        end
        chk("sparse_lock_bits", n,     49);
        chk("sparse_lock_clks", cyc_n, 147);
        repeat (3) begin vbit(1, 0); repeat (10) vbit(0, 0); end
        chk("pre_reset_count", cnt_a, 3);
        #2 reset = 1;
        #1;
        chk("async_locked", locked_a, 0);
        chk("async_count",  cnt_a,    0);
        chk("async_state",  st_a,     0);
        bit_valid = 0; clear_err = 0;
        m_reset();
        @(negedge clk);
        compare_all();
        reset = 0;

        // Saturation of the 4-bit counter and clear-vs-increment priority
        lock_count("sat_lock");
        for (int i = 0; i < 20; i++) begin
            vbit(1, 0);
            repeat (19) vbit(0, 0);
        end
        chk("sat_b",      cnt_b,    15);
        chk("sat_a",      cnt_a,    20);
        chk("sat_locked", locked_a, 1);
        vbit(1, 1);
        chk("clr_pulse", pulse_a, 1);
        chk("clr_count", cnt_a,   0);
        chk("clr_count_b", cnt_b, 0);

        // Randomized traffic: gaps, sparse errors, occasional clears
        for (int i = 0; i < 4000; i++) begin
            bit v, f, c;
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 99) == 0);
            c = ($urandom_range(0, 499) == 0);
            if (v) vbit(f, c);
            else   cyc($urandom_range(0, 1), 0, c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
